// File: rtl/periph_sample_fifo.sv
// GNSS IF sample capture peripheral: packs 2-bit RF samples into 32-bit words,
// buffers them in a FIFO and exposes CTRL/STATUS/DATA/THRESH on the MCU peripheral bus.
module periph_sample_fifo #(
   parameter int unsigned DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        rf_sample_valid,
   input  logic [1:0]  rf_sample,
   input  logic        periph_mem_valid,
   output logic        periph_mem_ready,
   input  logic [31:0] periph_mem_addr,
   input  logic [31:0] periph_mem_wdata,
   input  logic [3:0]  periph_mem_wstrb,
   output logic [31:0] periph_mem_rdata,
   output logic        irq
);

   localparam int AW = $clog2(DEPTH);

   logic              r_ready;
   logic [31:0]       r_rdata;
   logic              r_irq;
   logic              r_enable;
   logic              r_flush;
   logic              r_overflow;
   logic [AW:0]       r_thresh;
   logic [AW:0]       r_level;
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [3:0]        r_cnt;
   logic [31:0]       r_pack;
   logic [31:0]       r_mem [DEPTH];

   logic              w_accept;
   logic              w_hit;
   logic              w_rd;
   logic              w_wr;
   logic [1:0]        w_off;
   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_sample;
   logic              w_pushReq;
   logic              w_push;
   logic              w_overflowSet;
   logic              w_overflowClr;
   logic              w_ctrlWr;
   logic [31:0]       w_pushWord;
   logic [31:0]       w_head;
   logic [31:0]       w_status;
   logic [31:0]       w_rdData;
   logic [AW:0]       w_threshNext;
   logic              w_unused;

   // A request is taken only while ready is low, which forces an idle cycle between acks.
   assign w_accept = periph_mem_valid & ~r_ready;
   assign w_hit    = (periph_mem_addr[31:4] == BASE_ADDR[31:4]);
   assign w_rd     = w_accept & w_hit & (periph_mem_wstrb == 4'b0000);
   assign w_wr     = w_accept & w_hit & (periph_mem_wstrb != 4'b0000);
   assign w_off    = periph_mem_addr[3:2];
   assign w_ctrlWr = w_wr & (w_off == 2'd0) & periph_mem_wstrb[0];

   assign w_empty  = (r_level == '0);
   assign w_full   = (r_level == (AW+1)'(DEPTH));
   assign w_head   = r_mem[r_rptr];

   assign w_pop         = w_rd & (w_off == 2'd2) & ~w_empty;
   assign w_sample      = r_enable & rf_sample_valid & ~r_flush;
   assign w_pushReq     = w_sample & (r_cnt == 4'hF);
   assign w_push        = w_pushReq & (~w_full | w_pop);
   assign w_overflowSet = w_pushReq & w_full & ~w_pop;
   assign w_overflowClr = w_wr & (w_off == 2'd1) & periph_mem_wstrb[2] & periph_mem_wdata[18];

   assign w_status = {13'd0, r_overflow, w_full, w_empty, 16'(r_level)};
   assign w_unused = ^{periph_mem_addr[1:0], periph_mem_wdata};

   // The completing sample is merged in combinationally so the word can be pushed in the same cycle.
   always_comb begin
      w_pushWord = r_pack;
      w_pushWord[{r_cnt, 1'b0} +: 2] = rf_sample;
   end

   always_comb begin
      w_threshNext = r_thresh;
      for (int i = 0; i <= AW; i++) begin
         if (periph_mem_wstrb[i / 8]) w_threshNext[i] = periph_mem_wdata[i];
      end
   end

   always_comb begin
      w_rdData = '0;
      if (w_rd) begin
         case (w_off)
            2'd0:    w_rdData = {31'd0, r_enable};
            2'd1:    w_rdData = w_status;
            2'd2:    w_rdData = w_empty ? 32'd0 : w_head;
            default: w_rdData = {16'd0, 16'(r_thresh)};
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready    <= 1'b0;
         r_rdata    <= '0;
         r_irq      <= 1'b0;
         r_enable   <= 1'b0;
         r_flush    <= 1'b0;
         r_overflow <= 1'b0;
         r_thresh   <= '0;
         r_level    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_cnt      <= '0;
         r_pack     <= '0;
      end else begin
         r_ready <= w_accept;
         r_rdata <= w_rdData;
         r_flush <= w_ctrlWr & periph_mem_wdata[1];
         r_irq   <= r_enable & (r_thresh != '0) & (r_level >= r_thresh);

         if (w_ctrlWr) r_enable <= periph_mem_wdata[0];
         if (w_wr && (w_off == 2'd3)) r_thresh <= w_threshNext;

         // A simultaneous overflow event wins over a software clear.
         if (w_overflowClr) r_overflow <= 1'b0;
         if (w_overflowSet) r_overflow <= 1'b1;

         if (r_flush) begin
            r_cnt   <= '0;
            r_pack  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
         end else begin
            if (w_sample) begin
               r_cnt  <= r_cnt + 4'd1;
               r_pack <= (r_cnt == 4'hF) ? 32'd0 : w_pushWord;
            end
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (w_push) r_mem[r_wptr] <= w_pushWord;
   end

   assign periph_mem_ready = r_ready;
   assign periph_mem_rdata = r_rdata;
   assign irq              = r_irq;

endmodule
